// File: rtl/ram_bist_ctrl_pkg.sv
// Shared types for the RAM BIST sequencer: FSM state encoding and error-counter sizing.
package ram_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  // Error counter is ADDR_W plus this many bits, so two full passes of mismatches fit.
  localparam int unsigned ERR_EXTRA_W = 2;

endpackage

// File: rtl/bist_rd_pipe.sv
// Read-compare alignment pipe: delays {valid, addr, pat} of each issued read by RD_LAT
// clocks so the expected pattern arrives together with the RAM's read data.
module bist_rd_pipe #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_pat,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_pat
);

  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0]             pat_q, pat_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    vld_d     = vld_q;
    pat_d     = pat_q;
    addr_d    = addr_q;
    vld_d[0]  = in_valid;
    pat_d[0]  = in_pat;
    addr_d[0] = in_addr;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      pat_d[i]  = pat_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      pat_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      pat_q  <= pat_d;
      addr_q <= addr_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_pat   = pat_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// Two-pattern RAM BIST sequencer: writes addr / ~addr to every location, reads back,
// and reports pass/fail, a saturating error count and the first failing location.
module ram_bist_ctrl
  import ram_bist_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_W-1:0]          ram_q,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_data,
  output logic                       ram_wren,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ADDR_W+ERR_EXTRA_W-1:0] err_count,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic                       fail_pat
);

  localparam int unsigned ERR_W   = ADDR_W + ERR_EXTRA_W;
  localparam int unsigned DRAIN_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
  localparam logic [DATA_W-1:0] PAT0_MASK = '0;
  localparam logic [DATA_W-1:0] PAT1_MASK = '1;

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a, input logic p);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(a);
    return ext ^ (p ? PAT1_MASK : PAT0_MASK);
  endfunction

  bist_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 pat_q, pat_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 wren_q, wren_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [ADDR_W-1:0]    fail_addr_q, fail_addr_d;
  logic                 fail_pat_q, fail_pat_d;
  logic                 drain_last;
  logic                 cmp_vld, cmp_pat;
  logic [ADDR_W-1:0]    cmp_addr;

  assign drain_last = (drain_q == DRAIN_W'(RD_LAT - 1));

  bist_rd_pipe #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == ST_READ),
    .in_addr   (addr_q),
    .in_pat    (pat_q),
    .out_valid (cmp_vld),
    .out_addr  (cmp_addr),
    .out_pat   (cmp_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WRITE;
      ST_WRITE:         if (addr_q == LAST_ADDR) state_d = ST_READ;
      ST_READ:          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN:         if (drain_last) state_d = pat_q ? ST_DONE : ST_WRITE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with the state they describe.
  always_comb begin : outputs
    addr_d      = addr_q;
    pat_d       = pat_q;
    drain_d     = drain_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_pat_d  = fail_pat_q;

    if (cmp_vld && (ram_q != exp_data(cmp_addr, cmp_pat))) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        fail_addr_d = cmp_addr;
        fail_pat_d  = cmp_pat;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d      = '0;
          pat_d       = 1'b0;
          drain_d     = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_pat_d  = 1'b0;
        end
      end
      ST_WRITE: addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      ST_READ:  if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
      ST_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_last) begin
          drain_d = '0;
          if (!pat_q) begin
            pat_d  = 1'b1;
            addr_d = '0;
          end
        end
      end
      default: ;
    endcase

    wren_d = (state_d == ST_WRITE);
    data_d = wren_d ? exp_data(addr_d, pat_d) : '0;
    busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      pat_q       <= 1'b0;
      drain_q     <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_pat_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      drain_q     <= drain_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_pat_q  <= fail_pat_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  assign ram_wren  = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_pat  = fail_pat_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (RD_LAT=1 with injectable RAM faults, RD_LAT=2
// fault-free) checked every cycle against a cycle-index model of the test sequence.
module tb_ram_bist_ctrl;

  localparam int N  = 32;
  localparam int EW = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [1:0][4:0]       ram_addr, fail_addr;
  logic [1:0][7:0]       ram_data, ram_q;
  logic [1:0]            ram_wren, busy, done, pass, fail_pat;
  logic [1:0][EW-1:0]    err_count;

  int fmode;
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  // Model: mst 0=idle 1=running 2=done; mt = edges since the start edge
  int mst[2], mt[2], merr[2], mfa[2], mfp[2];

  always #5 clk = ~clk;

  function automatic logic [7:0] fault_q(input int mode, input logic [4:0] a, input logic [7:0] raw);
    if (mode == 1 && a == 5'd9) return raw & 8'hF7;
    if (mode == 2) return 8'hAA;
    return raw;
  endfunction

  function automatic logic [7:0] pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a);
    return (p != 0) ? ~v : v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_bist_ctrl #(.DATA_W(8), .ADDR_W(5), .RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ram_q     (ram_q[g]),
      .ram_addr  (ram_addr[g]),
      .ram_data  (ram_data[g]),
      .ram_wren  (ram_wren[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (err_count[g]),
      .fail_addr (fail_addr[g]),
      .fail_pat  (fail_pat[g])
    );

    logic [7:0] mem [N];
    logic [7:0] rp [0:g];
    initial for (int k = 0; k < N; k++) mem[k] = 8'h00;
    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_addr[g]] <= ram_data[g];
      rp[0] <= fault_q((g == 0) ? fmode : 0, ram_addr[g], mem[ram_addr[g]]);
      for (int k = 1; k <= g; k++) rp[k] <= rp[k-1];
    end
    assign ram_q[g] = rp[g];
  end

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; mt[i] = 0; merr[i] = 0; mfa[i] = 0; mfp[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i, input logic s);
    int lat, per, r, u, a, p;
    logic [7:0] e;
    lat = i + 1;
    per = 2 * N + lat;
    if (mst[i] != 1) begin
      if (s) begin
        mst[i] = 1; mt[i] = 0; merr[i] = 0; mfa[i] = 0; mfp[i] = 0;
      end
    end else begin
      mt[i]++;
      r = mt[i] - lat - 1;   // the read whose compare lands on this edge
      if (r >= 0) begin
        u = r % per;
        if (u >= N && u < 2 * N) begin
          a = u - N;
          p = r / per;
          e = pat(a, p);
          if (fault_q((i == 0) ? fmode : 0, 5'(a), e) != e) begin
            if (merr[i] == 0) begin mfa[i] = a; mfp[i] = p; end
            if (merr[i] < 127) merr[i]++;
          end
        end
      end
      if (mt[i] == 2 * per) mst[i] = 2;
    end
  endfunction

  function automatic logic [31:0] exp_vec(input int i);
    int per, p, u;
    logic [4:0] a;
    logic [7:0] d;
    logic w, b, dn, ps;
    a = '0; d = '0; w = 1'b0; b = 1'b0; dn = 1'b0; ps = 1'b0;
    per = 2 * N + i + 1;
    if (mst[i] == 1) begin
      p = mt[i] / per;
      u = mt[i] % per;
      b = 1'b1;
      if (u < N) begin a = 5'(u); w = 1'b1; d = pat(u, p); end
      else if (u < 2 * N) a = 5'(u - N);
      else a = 5'(N - 1);
    end else if (mst[i] == 2) begin
      a = 5'(N - 1); dn = 1'b1; ps = (merr[i] == 0);
    end
    return 32'({a, d, w, b, dn, ps, 7'(merr[i]), 5'(mfa[i]), 1'(mfp[i])});
  endfunction

  function automatic logic [31:0] act_vec(input int i);
    return 32'({ram_addr[i], ram_data[i], ram_wren[i], busy[i], done[i], pass[i],
                err_count[i], fail_addr[i], fail_pat[i]});
  endfunction

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) check_vec($sformatf("outs%0d", i), act_vec(i), exp_vec(i));
    end
  end

  task automatic tick(input logic st);
    start = st;
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 2; i++) model_step(i, st);
    @(negedge clk);
  endtask

  task automatic wait_done(input bit noise, output int e0, output int e1);
    e0 = -1;
    e1 = -1;
    for (int k = 1; k <= 300 && (e0 < 0 || e1 < 0); k++) begin
      tick((noise && k < 120) ? 1'($urandom_range(0, 3) == 0) : 1'b0);
      if (e0 < 0 && done[0]) e0 = k;
      if (e1 < 0 && done[1]) e1 = k;
    end
    if (e0 < 0 || e1 < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: got e0=%0d e1=%0d expected both done", e0, e1);
    end
  endtask

  initial begin
    int e0, e1;
    rst_n = 1'b0;
    start = 1'b0;
    fmode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_vec("reset0", act_vec(0), 32'd0);
    check_vec("reset1", act_vec(1), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fault-free run
    tick(1'b1);
    check_vec("first_write", 32'({ram_wren[0], ram_addr[0], ram_data[0]}), 32'({1'b1, 5'd0, 8'h00}));
    wait_done(1'b0, e0, e1);
    check_int("t1_done_edge_lat1", e0, 130);
    check_int("t1_done_edge_lat2", e1, 132);
    check_vec("t1_result", 32'({pass, err_count[0], err_count[1]}), 32'({2'b11, 7'd0, 7'd0}));

    // Bit 3 forced low at address 9
    fmode = 1;
    tick(1'b1);
    wait_done(1'b0, e0, e1);
    check_int("t2_done_edge", e0, 130);
    check_vec("t2_result", 32'({pass[0], err_count[0], fail_addr[0], fail_pat[0]}),
              32'({1'b0, 7'd1, 5'd9, 1'b0}));

    // Stuck-at 0xAA everywhere
    fmode = 2;
    tick(1'b1);
    wait_done(1'b0, e0, e1);
    check_vec("t3_result", 32'({pass[0], err_count[0], fail_addr[0], fail_pat[0]}),
              32'({1'b0, 7'd64, 5'd0, 1'b0}));

    // Reset during pass-1 READ, then a clean rerun
    fmode = 0;
    tick(1'b1);
    repeat (107) tick(1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_vec("midreset0", act_vec(0), 32'd0);
    check_vec("midreset1", act_vec(1), 32'd0);
    @(negedge clk);
    tick(1'b0);
    rst_n = 1'b1;
    tick(1'b1);
    wait_done(1'b0, e0, e1);
    check_int("t4_done_edge", e0, 130);
    check_vec("t4_pass", 32'(pass), 32'(2'b11));

    // Start pulses while busy are ignored
    tick(1'b1);
    wait_done(1'b1, e0, e1);
    check_int("t5_done_edge_lat1", e0, 130);
    check_int("t5_done_edge_lat2", e1, 132);

    // Start from DONE reruns the test
    tick(1'b1);
    check_vec("rerun_from_done", 32'({done[0], busy[0]}), 32'(2'b01));
    wait_done(1'b0, e0, e1);
    check_int("rerun_done_edge", e0, 130);

    // Randomised fault mode with start noise
    for (int r = 0; r < 3; r++) begin
      fmode = int'($urandom_range(0, 2));
      tick(1'b1);
      wait_done(1'b1, e0, e1);
      check_int("rand_done_edge", e0, 130);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
